// File: rtl/calc_cmd_issuer.sv
// rtl/calc_cmd_issuer.sv - FIFO-buffered command issuer driving a combinational calculator
// Optional: CALC_RSP_TAG_EN adds a 3-bit issue tag (rsp_tag) returned with each response.
module calc_cmd_issuer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_in,
  input  logic [1:0]               cmd_flag,
  output logic [2:0]               calc_in,
  output logic [1:0]               calc_flag,
  input  logic [7:0]               calc_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_data,
  output logic [1:0]               rsp_flag,
`ifdef CALC_RSP_TAG_EN
  output logic [2:0]               rsp_tag,
`endif
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [2:0]         calc_in_q, calc_in_d;
  logic [1:0]         calc_flag_q, calc_flag_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic [1:0]         rsp_flag_q, rsp_flag_d;
  logic [4:0]         mem_q [DEPTH];
  logic [4:0]         head;
  logic               full, empty, push, pop, sample;

  // Occupancy comes from the registered level only, so nothing passes through in one cycle.
  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign cmd_ready = reset && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && !empty;
  assign sample    = (state_q == WAIT) && (cnt_q == '0);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    calc_in_d   = calc_in_q;
    calc_flag_d = calc_flag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flag_d  = rsp_flag_q;
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
    case (state_q)
      IDLE: begin
        if (pop) begin
          calc_in_d   = head[2:0];
          calc_flag_d = head[4:3];
          cnt_d       = CNT_W'(SETTLE - 1);
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (sample) begin
          rsp_data_d  = calc_out;
          rsp_flag_d  = calc_flag_q;
          rsp_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      calc_in_q   <= '0;
      calc_flag_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      calc_in_q   <= calc_in_d;
      calc_flag_q <= calc_flag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flag_q  <= rsp_flag_d;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_flag, cmd_in};
  end

`ifdef CALC_RSP_TAG_EN
  logic [2:0] issue_cnt_q, cmd_tag_q, rsp_tag_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_cnt_q <= '0;
      cmd_tag_q   <= '0;
      rsp_tag_q   <= '0;
    end else begin
      if (pop) begin
        issue_cnt_q <= issue_cnt_q + 3'd1;
        cmd_tag_q   <= issue_cnt_q;
      end
      if (sample) rsp_tag_q <= cmd_tag_q;
    end
  end

  assign rsp_tag = rsp_tag_q;
`endif

  assign calc_in   = calc_in_q;
  assign calc_flag = calc_flag_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flag  = rsp_flag_q;
  assign busy      = (state_q != IDLE);
  assign level     = level_q;

endmodule

// File: tb/tb_calc_cmd_issuer.sv
// tb/tb_calc_cmd_issuer.sv - scoreboard bench for calc_cmd_issuer with a calculator stub
module tb_calc_cmd_issuer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_in;
  logic [1:0] cmd_flag;
  logic [2:0] calc_in;
  logic [1:0] calc_flag;
  logic [7:0] calc_out;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_flag;
  logic       busy;
  logic [2:0] level;
`ifdef CALC_RSP_TAG_EN
  logic [2:0] rsp_tag;
  logic [2:0] exp_tag;
`endif

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q [$];

  calc_cmd_issuer #(.DEPTH(4), .SETTLE(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_in(cmd_in), .cmd_flag(cmd_flag),
    .calc_in(calc_in), .calc_flag(calc_flag), .calc_out(calc_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flag(rsp_flag),
`ifdef CALC_RSP_TAG_EN
    .rsp_tag(rsp_tag),
`endif
    .busy(busy), .level(level)
  );

  assign calc_out = {3'b000, calc_flag, calc_in};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected entry is {flag, data}, queued when the command is accepted.
  task automatic push(input logic [2:0] v, input logic [1:0] f, input logic [7:0] exp_data);
    int n = 0;
    cmd_in = v; cmd_flag = f; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      chk("push_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({f, exp_data});
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rsp_valid) chk("rsp_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_rsp();
    wait_valid();
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {22'd0, rsp_flag, rsp_data}, 32'hFFFF);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e[7:0]);
          chk("rsp_flag", rsp_flag, e[9:8]);
`ifdef CALC_RSP_TAG_EN
          chk("rsp_tag", rsp_tag, exp_tag);
          exp_tag = exp_tag + 3'd1;
`endif
        end
      end
    end
  end

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_in = '0; cmd_flag = '0; rsp_ready = 1'b0;
`ifdef CALC_RSP_TAG_EN
    exp_tag = '0;
`endif
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_calc_in", calc_in, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1);

    // Single command: pop at P, response valid after P+2, gone after P+3
    @(posedge clk); #1 rsp_ready = 1'b1;
    push(3'd5, 2'd2, 8'h15);
    @(negedge clk);
    chk("single_level", level, 1);
    @(negedge clk);
    chk("single_calc_in", calc_in, 5);
    chk("single_calc_flag", calc_flag, 2);
    chk("single_busy", busy, 1);
    @(negedge clk);
    chk("single_valid_early", rsp_valid, 0);
    @(negedge clk);
    chk("single_valid", rsp_valid, 1);
    @(negedge clk);
    chk("single_valid_drop", rsp_valid, 0);

    // FIFO full under backpressure
    @(posedge clk); #1 rsp_ready = 1'b0;
    push(3'd1, 2'd0, 8'h01);
    push(3'd2, 2'd0, 8'h02);
    push(3'd3, 2'd0, 8'h03);
    push(3'd4, 2'd0, 8'h04);
    push(3'd5, 2'd0, 8'h05);
    @(negedge clk);
    chk("full_level", level, 4);
    chk("full_cmd_ready", cmd_ready, 0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_data", rsp_data, 8'h01);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_calc_in", calc_in, 1);
      chk("bp_busy", busy, 1);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) pulse_rsp();
    repeat (2) @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_level", level, 0);
    chk("drain_busy", busy, 0);
    chk("hold_calc_in", calc_in, 5);

    // Reset while in WAIT with two commands queued
    @(posedge clk); #1 rsp_ready = 1'b1;
    push(3'd7, 2'd1, 8'h0F);
    push(3'd6, 2'd3, 8'h1E);
    push(3'd2, 2'd0, 8'h02);
    reset = 1'b0;
    exp_q.delete();
`ifdef CALC_RSP_TAG_EN
    exp_tag = '0;
`endif
    @(negedge clk);
    chk("mid_level_pre", level, 2);
    chk("mid_busy_pre", busy, 1);
    chk("mid_calc_in_pre", calc_in, 7);
    @(negedge clk);
    chk("mid_level", level, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_calc_in", calc_in, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_no_rsp", rsp_valid, 0);

    // Nine commands streamed with rsp_ready high
    @(posedge clk); #1;
    push(3'd0, 2'd0, 8'h00);
    push(3'd1, 2'd1, 8'h09);
    push(3'd2, 2'd2, 8'h12);
    push(3'd3, 2'd3, 8'h1B);
    push(3'd4, 2'd0, 8'h04);
    push(3'd5, 2'd1, 8'h0D);
    push(3'd6, 2'd2, 8'h16);
    push(3'd7, 2'd3, 8'h1F);
    push(3'd0, 2'd1, 8'h08);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        n++;
        @(negedge clk);
      end
    end
    chk("stream_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_cmd_issuer.md
Name: calc_cmd_issuer

Overview:
- Host-facing command issuer that is the driving end of the calculator interface.
- Accepts {operand, flag} commands through a valid/ready handshake and buffers them in a small FIFO.
- Presents one command at a time on the calculator's in/flag inputs, waits a fixed settle time, then samples the calculator's 8-bit out.
- Returns the sampled value to the host through a valid/ready response channel.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- SETTLE, 2, cycles calc_in/calc_flag are held stable before calc_out is sampled; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset: reset==0 at a rising clk edge resets the block.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_in  in  3  operand.
- cmd_flag  in  2  operation select.
- calc_in  out  3  to calculator in.
- calc_flag  out  2  to calculator flag.
- calc_out  in  8  from calculator out; treated as combinational.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  8  sampled calc_out.
- rsp_flag  out  2  flag of the command that produced rsp_data.
- busy  out  1  FSM not in IDLE.
- level  out  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (reset==0 at clk edge):
  - FIFO flushed, level=0, FSM=IDLE.
  - calc_in=0, calc_flag=0, rsp_valid=0, rsp_data=0, rsp_flag=0, busy=0.
  - cmd_ready is forced 0 while reset==0.
  - Reset mid-operation drops any in-flight command and any pending response.
- Push: on cmd_valid && cmd_ready at an edge. cmd_ready = !full, combinational from level.
- No FIFO pass-through:
  - A command pushed into an empty FIFO is eligible to pop on the next edge at the earliest.
  - When full, a same-edge pop does not raise cmd_ready in that cycle.
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - If FIFO is non-empty at the edge: pop the head, calc_in<=head.in, calc_flag<=head.flag, cnt<=SETTLE-1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: rsp_data<=calc_out, rsp_flag<=calc_flag, rsp_valid<=1, go to HOLD.
  - calc_out is therefore sampled at the SETTLE-th edge after the pop edge.
- HOLD:
  - rsp_valid, rsp_data and rsp_flag are held stable until rsp_ready.
  - On rsp_ready at an edge: rsp_valid<=0, go to IDLE.
  - rsp_ready while rsp_valid==0 is ignored.
- calc_in and calc_flag keep the last issued command's values between commands; they never glitch back to 0 except on reset.
- Throughput: with rsp_ready held high, one command per SETTLE+2 cycles.
- Pushes are accepted in every state while not full. Simultaneous push and pop in the same cycle leaves level unchanged.
- Commands are issued strictly in FIFO order; no reordering or dropping except on reset.
- FIFO pointers wrap modulo DEPTH. level ranges 0..DEPTH.

Optional Feature:
- Macro: CALC_RSP_TAG_EN.
- Defined:
  - Adds output port rsp_tag [2:0].
  - A 3-bit issue counter (reset 0) increments on every pop and wraps 7->0.
  - The counter value at pop travels with the command and is presented on rsp_tag together with rsp_data.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- All bench cases use a calculator stub with calc_out = {3'b000, calc_flag, calc_in}.
- Reset:
  - Stimulus: hold reset=0 for 2 edges, then release.
  - Response: calc_in=0, rsp_valid=0, level=0, cmd_ready=0 during reset, cmd_ready=1 after release.
- Single command:
  - Stimulus: push in=5, flag=2 with rsp_ready=1.
  - Response: calc_in=5 and calc_flag=2 from pop edge P; rsp_valid=1 after edge P+2 with rsp_data=0x15, rsp_flag=2; rsp_valid=0 one edge later.
- FIFO full:
  - Stimulus: rsp_ready=0; push 5 commands back-to-back (in=1,2,3,4,5).
  - Response: the first command is popped, so 5 commands are accepted and level=4; cmd_ready=0 afterward; responses return 0x01, 0x02, 0x03, 0x04, 0x05 in order as rsp_ready is pulsed.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles after rsp_valid rises.
  - Response: rsp_data holds stable; calc_in does not advance to the next queued command; busy=1.
- Reset mid-operation:
  - Stimulus: assert reset=0 while in WAIT with level=2.
  - Response: after one edge level=0, rsp_valid=0, FSM=IDLE, no response is ever produced for the flushed commands.
- CALC_RSP_TAG_EN:
  - Stimulus: issue 9 commands.
  - Response: rsp_tag sequence 0,1,2,3,4,5,6,7,0.
